conv_driver: RTL and testbench
==============================

Name: conv_driver

Overview:
Transmit side of the convolution engine's input stream protocol, and receiver of its result stream. The host loads a filter and an image into local buffers and pulses start. The block then replays them onto the engine's filter_valid/image_valid/in_data interface with the mode sideband, with correct framing and inter-phase gap. It collects the n*n returned results, forwards them with a last flag, and flags protocol errors and timeouts.

Parameters:
GAP_CYCLES, 1, idle cycles between filter_valid falling and image_valid rising (legal values 1..7)
TIMEOUT, 256, max cycles allowed between consecutive results (or from last pixel sent to first result) before err

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  host buffer write strobe
wr_sel  in  1  0 = filter buffer, 1 = image buffer
wr_addr  in  6  row-major index (filter 0..24, image 0..63)
wr_data  in  8  signed sample
start  in  1  one-cycle job launch
cfg_filter_size  in  1  0 = 3x3, 1 = 5x5
cfg_image_size  in  4  n, legal 4..8
cfg_pad_mode  in  1  0 = zero pad, 1 = replicate pad
cfg_act_mode  in  1  0 = ReLU, 1 = leaky
busy  out  1  job in progress
filter_valid  out  1  to engine
image_valid  out  1  to engine
filter_size  out  1  to engine
image_size  out  4  to engine
pad_mode  out  1  to engine
act_mode  out  1  to engine
in_data  out  8  signed sample to engine
out_valid  in  1  from engine
out_data  in  16  signed result from engine
res_valid  out  1  forwarded result valid
res_data  out  16  forwarded result
res_last  out  1  high with the n*n-th result
done  out  1  one-cycle pulse, job completed cleanly
err  out  1  one-cycle pulse, job aborted (timeout / short stream / bad config)

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Buffer contents are not reset. Reset mid-job aborts immediately; no done/err is produced.
- Writes are accepted only when busy = 0. Writes while busy, and writes with wr_sel = 0 and wr_addr > 24, are ignored.
- The config is latched on the start cycle while in IDLE. A start while busy is ignored.
- Illegal image_size (<4 or >8): err pulses at T+1, nothing is transmitted, and the FSM stays in IDLE.
- FSM states: IDLE -> FILT -> GAP -> IMG -> WAIT -> IDLE.
- IDLE -> FILT on a legal start at cycle T. busy rises at T+1.
- FILT: filter_valid = 1 for k*k consecutive cycles (k = 3 or 5), starting at T+1. in_data = filter[0..k*k-1] in row-major order, one element per cycle. filter_size/image_size/pad_mode/act_mode hold the latched config from T+1 until IDLE; this is mandatory on the first filter_valid cycle.
- GAP: filter_valid = image_valid = 0 for exactly GAP_CYCLES cycles. in_data = 0.
- IMG: image_valid = 1 for n*n consecutive cycles. in_data = image[0..n*n-1] in row-major order. in_data = 0 whenever no valid is high.
- WAIT: entered after the last pixel; in_data = 0.
- Result capture is active in both IMG and WAIT, because the engine starts producing results before the image stream ends.
- Each out_valid = 1 cycle: res_valid = 1 and res_data = out_data, registered (1-cycle latency). The result counter increments.
- res_last = 1 with result n*n. done pulses in the same cycle as that res_last. FSM returns to IDLE and busy falls in the same cycle.
- out_valid = 0 after at least one result but before n*n results: err pulses and the FSM returns to IDLE. The engine emits results contiguously, so a gap is a short stream.
- Watchdog: counts cycles since the last result (or since the last pixel, if no result yet). Reaching TIMEOUT in WAIT triggers err and a return to IDLE.
- out_valid while in IDLE is ignored: no res_valid.
- Counter widths: 5-bit filter index, 6-bit pixel index, 7-bit result count (max 64), watchdog sized by $clog2(TIMEOUT+1).
- Back-to-back jobs: a new start is accepted in the cycle busy falls + 1. The engine is idle by then.

Decomposition:
- Shared package conv_pkg holds:
  - typedef enum drv_state_t {IDLE, FILT, GAP, IMG, WAIT}
  - constants MAX_IMG_N = 8, MIN_IMG_N = 4, FILT3_LEN = 9, FILT5_LEN = 25
  - the mode encodings for filter_size, pad_mode and act_mode
- One sub-module: conv_drv_buf. It holds the 25x8 filter array and the 64x8 image array, with a host write port and combinational read by index. The top level keeps the FSM, counters, watchdog and result path.

Test Plan:
- 3x3 filter 1..9, n = 4, image 1..16, pad 0, act 0, start at T -> filter_valid high T+1..T+9 with in_data 1..9; image_valid high T+11..T+26 with in_data 1..16; engine returns 16 results -> 16 res_valid, res_last on the 16th, done pulse, busy falls.
- 5x5 filter, n = 8, GAP_CYCLES = 3, pad 1, act 1 -> 25 filter cycles, exactly 3 gap cycles, 64 image cycles; mode outputs stable from the first filter cycle to the end; 64 results, then done.
- start with cfg_image_size = 2 -> err at T+1; filter_valid never rises; busy stays 0.
- Engine model drops out_valid after 10 of 16 results -> err pulse, no res_last, FSM back in IDLE; the next job completes normally.
- Engine model never responds, TIMEOUT = 256 -> err exactly 256 cycles after the last pixel.
- rst asserted mid-IMG -> all outputs 0 the next cycle; start with unchanged buffers replays identical in_data.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine stream driver.
//   drv_state_t      : driver FSM state encoding
//   MIN/MAX_IMG_N    : legal image edge length range
//   FILT3/5_LEN      : filter stream lengths for 3x3 and 5x5 kernels
//   *_3X3/5X5, PAD_*, ACT_* : sideband mode encodings seen by the engine
package conv_pkg;

  typedef enum logic [2:0] {IDLE, FILT, GAP, IMG, WAIT} drv_state_t;

  localparam int DATA_W    = 8;
  localparam int RES_W     = 16;
  localparam int MAX_IMG_N = 8;
  localparam int MIN_IMG_N = 4;
  localparam int FILT3_LEN = 9;
  localparam int FILT5_LEN = 25;

  localparam logic FILT_3X3  = 1'b0;
  localparam logic FILT_5X5  = 1'b1;
  localparam logic PAD_ZERO  = 1'b0;
  localparam logic PAD_REPL  = 1'b1;
  localparam logic ACT_RELU  = 1'b0;
  localparam logic ACT_LEAKY = 1'b1;

  function automatic logic [4:0] filt_len(input logic fs);
    return (fs == FILT_5X5) ? 5'(FILT5_LEN) : 5'(FILT3_LEN);
  endfunction

endpackage

// File: rtl/conv_driver_if.sv
// Engine-facing stream bus of the convolution driver.
//   master : driver side (drives valids, sideband, in_data; receives results)
//   slave  : engine side
interface conv_driver_if;
  import conv_pkg::*;

  logic                      filter_valid;
  logic                      image_valid;
  logic                      filter_size;
  logic [3:0]                image_size;
  logic                      pad_mode;
  logic                      act_mode;
  logic signed [DATA_W-1:0]  in_data;
  logic                      out_valid;
  logic signed [RES_W-1:0]   out_data;

  modport master (
    output filter_valid, image_valid, filter_size, image_size,
           pad_mode, act_mode, in_data,
    input  out_valid, out_data
  );

  modport slave (
    input  filter_valid, image_valid, filter_size, image_size,
           pad_mode, act_mode, in_data,
    output out_valid, out_data
  );

endinterface

// File: rtl/conv_drv_buf.sv
// Filter (25 x DATA_W) and image (64 x DATA_W) sample buffers.
//   clk              : clock
//   filt_we / img_we : qualified host write enables
//   wr_addr/wr_data  : host write address and sample
//   filt_idx/img_idx : combinational read indices
//   filt_rd/img_rd   : read samples
// Storage is deliberately not reset so a job can be replayed after reset.
module conv_drv_buf
  import conv_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     filt_we,
  input  logic                     img_we,
  input  logic [5:0]               wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [4:0]               filt_idx,
  input  logic [5:0]               img_idx,
  output logic signed [DATA_W-1:0] filt_rd,
  output logic signed [DATA_W-1:0] img_rd
);

  logic signed [DATA_W-1:0] filt_mem [FILT5_LEN];
  logic signed [DATA_W-1:0] img_mem  [MAX_IMG_N*MAX_IMG_N];

  always_ff @(posedge clk) begin
    if (filt_we) filt_mem[wr_addr[4:0]] <= wr_data;
    if (img_we)  img_mem[wr_addr]       <= wr_data;
  end

  // Indices beyond the filter array read as zero rather than X.
  assign filt_rd = (filt_idx < 5'(FILT5_LEN)) ? filt_mem[filt_idx] : '0;
  assign img_rd  = img_mem[img_idx];

endmodule

// File: rtl/conv_driver.sv
// Convolution engine stream driver.
// Replays a host-loaded filter and image onto the engine stream (filter
// phase, fixed gap, image phase), then collects the n*n results, forwards
// them with a last flag and reports done or err (short stream, timeout,
// bad config).
//   clk, rst         : clock, synchronous active-high reset
//   wr_*             : host buffer write port (ignored while busy)
//   start, cfg_*     : job launch and configuration (latched on start)
//   busy             : job in progress
//   eng              : engine stream bus (master side)
//   res_valid/data/last : forwarded results, one cycle after out_valid
//   done, err        : one-cycle completion / abort pulses
module conv_driver
  import conv_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [5:0]               wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     start,
  input  logic                     cfg_filter_size,
  input  logic [3:0]               cfg_image_size,
  input  logic                     cfg_pad_mode,
  input  logic                     cfg_act_mode,
  output logic                     busy,
  conv_driver_if.master            eng,
  output logic                     res_valid,
  output logic signed [RES_W-1:0]  res_data,
  output logic                     res_last,
  output logic                     done,
  output logic                     err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  drv_state_t state_q, state_d;

  logic [4:0]      fidx_q;
  logic [5:0]      pidx_q;
  logic [2:0]      gcnt_q;
  logic [6:0]      res_cnt_q;
  logic [WD_W-1:0] wd_q;
  logic [6:0]      npix_q;

  logic            cfg_fs_q;
  logic [3:0]      cfg_n_q;
  logic            cfg_pad_q;
  logic            cfg_act_q;

  logic            cfg_bad;
  logic            launch;
  logic            capture;
  logic            done_d;
  logic            err_d;
  logic            res_vld_d;

  logic                     res_vld_p1;
  logic signed [RES_W-1:0]  res_data_p1;
  logic                     res_last_p1;
  logic                     done_q;
  logic                     err_q;

  logic signed [DATA_W-1:0] filt_rd;
  logic signed [DATA_W-1:0] img_rd;
  logic                     filt_we;
  logic                     img_we;

  assign busy    = (state_q != IDLE);
  assign filt_we = wr_en && !busy && !wr_sel && (wr_addr <= 6'(FILT5_LEN - 1));
  assign img_we  = wr_en && !busy &&  wr_sel;
  assign cfg_bad = (cfg_image_size < 4'(MIN_IMG_N)) || (cfg_image_size > 4'(MAX_IMG_N));

  conv_drv_buf #(.DATA_W(DATA_W)) u_buf (
    .clk      (clk),
    .filt_we  (filt_we),
    .img_we   (img_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .filt_idx (fidx_q),
    .img_idx  (pidx_q),
    .filt_rd  (filt_rd),
    .img_rd   (img_rd)
  );

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    capture   = (state_q == IMG) || (state_q == WAIT);
    res_vld_d = capture && eng.out_valid;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = FILT;
          end
        end
      end
      FILT: if (fidx_q == filt_len(cfg_fs_q) - 5'd1) state_d = GAP;
      GAP:  if (gcnt_q == 3'(GAP_CYCLES - 1)) state_d = IMG;
      IMG:  if ({1'b0, pidx_q} == npix_q - 7'd1) state_d = WAIT;
      WAIT: ;
      default: state_d = IDLE;
    endcase

    // Results may arrive while pixels are still streaming; completion or
    // an abort overrides the streaming transition.
    if (capture) begin
      if (eng.out_valid) begin
        if (res_cnt_q + 7'd1 == npix_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end else if (res_cnt_q != 7'd0) begin
        // The engine emits results back to back, so a hole is a short stream.
        err_d   = 1'b1;
        state_d = IDLE;
      end else if ((state_q == WAIT) && (wd_q == WD_W'(TIMEOUT - 1))) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fidx_q      <= '0;
      pidx_q      <= '0;
      gcnt_q      <= '0;
      res_cnt_q   <= '0;
      wd_q        <= '0;
      npix_q      <= '0;
      cfg_fs_q    <= FILT_3X3;
      cfg_n_q     <= '0;
      cfg_pad_q   <= PAD_ZERO;
      cfg_act_q   <= ACT_RELU;
      res_vld_p1  <= 1'b0;
      res_data_p1 <= '0;
      res_last_p1 <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      err_q       <= err_d;
      // p0 -> p1: engine result registered toward the host
      res_vld_p1  <= res_vld_d;
      res_last_p1 <= done_d;
      if (res_vld_d) begin
        res_data_p1 <= eng.out_data;
        res_cnt_q   <= res_cnt_q + 7'd1;
      end

      if (launch) begin
        cfg_fs_q  <= cfg_filter_size;
        cfg_n_q   <= cfg_image_size;
        cfg_pad_q <= cfg_pad_mode;
        cfg_act_q <= cfg_act_mode;
        npix_q    <= {3'b0, cfg_image_size} * {3'b0, cfg_image_size};
        fidx_q    <= '0;
        pidx_q    <= '0;
        gcnt_q    <= '0;
        res_cnt_q <= '0;
        wd_q      <= '0;
      end

      case (state_q)
        FILT: fidx_q <= fidx_q + 5'd1;
        GAP:  gcnt_q <= gcnt_q + 3'd1;
        IMG: begin
          pidx_q <= pidx_q + 6'd1;
          // Watchdog measures from the most recent pixel until results flow.
          wd_q   <= WD_W'(1);
        end
        WAIT: wd_q <= eng.out_valid ? WD_W'(1) : wd_q + WD_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    eng.in_data = '0;
    if (state_q == FILT)     eng.in_data = filt_rd;
    else if (state_q == IMG) eng.in_data = img_rd;
  end

  assign eng.filter_valid = (state_q == FILT);
  assign eng.image_valid  = (state_q == IMG);
  assign eng.filter_size  = busy ? cfg_fs_q  : 1'b0;
  assign eng.image_size   = busy ? cfg_n_q   : 4'd0;
  assign eng.pad_mode     = busy ? cfg_pad_q : 1'b0;
  assign eng.act_mode     = busy ? cfg_act_q : 1'b0;

  assign res_valid = res_vld_p1;
  assign res_data  = res_data_p1;
  assign res_last  = res_last_p1;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_driver.sv
// Randomized bench for conv_driver with a cycle-schedule reference model.
module tb_conv_driver;

  localparam int GAP_N = 3;
  localparam int TMO   = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              wr_en, wr_sel, start;
  logic [5:0]        wr_addr;
  logic signed [7:0] wr_data;
  logic              cfg_filter_size, cfg_pad_mode, cfg_act_mode;
  logic [3:0]        cfg_image_size;
  logic              busy, res_valid, res_last, done, err;
  logic signed [15:0] res_data;

  conv_driver_if eng();

  conv_driver #(.GAP_CYCLES(GAP_N), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_sel          (wr_sel),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .cfg_filter_size (cfg_filter_size),
    .cfg_image_size  (cfg_image_size),
    .cfg_pad_mode    (cfg_pad_mode),
    .cfg_act_mode    (cfg_act_mode),
    .busy            (busy),
    .eng             (eng),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .res_last        (res_last),
    .done            (done),
    .err             (err)
  );

  int checks = 0;
  int errors = 0;

  // Host-visible buffer contents as the host believes them to be.
  logic signed [7:0] fm [25];
  logic signed [7:0] im [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input logic signed [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel) im[addr] = data;
    else if (addr <= 24) fm[addr] = data;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " fv"}, eng.filter_valid, 0);
    chk({tag, " iv"}, eng.image_valid, 0);
    chk({tag, " in_data"}, eng.in_data, 0);
    chk({tag, " modes"}, {eng.filter_size, eng.image_size, eng.pad_mode, eng.act_mode}, 0);
    chk({tag, " res"}, {res_valid, res_last, done, err}, 0);
    chk({tag, " res_data"}, res_data, 0);
  endtask

  // mode 0: full result stream, 1: stream stops after d results, 2: engine silent.
  // lat: first result cycle relative to the last pixel cycle.
  // abort_c: cycle (after start) in which rst is raised, 0 = never.
  task automatic run_job(input bit fs, input int n, input bit pad, input bit act,
                         input int mode, input int d, input int lat, input int abort_c);
    int k, np, img_lo, img_hi, r0, endc, nres;
    bit pov, ov, busy_e, fv_e, iv_e;
    logic signed [15:0] pod;
    logic signed [7:0]  ein;
    k      = fs ? 25 : 9;
    np     = n * n;
    img_lo = k + GAP_N + 1;
    img_hi = k + GAP_N + np;
    r0     = img_hi + lat;
    if (r0 < img_lo) r0 = img_lo;
    nres   = (mode == 0) ? np : (mode == 1) ? d : 0;
    endc   = (mode == 0) ? r0 + np : (mode == 1) ? r0 + d + 1 : img_hi + TMO;

    cfg_filter_size = fs; cfg_image_size = 4'(n);
    cfg_pad_mode = pad; cfg_act_mode = act;
    start = 1'b1; wr_en = 1'b0;
    eng.out_valid = 1'($urandom); eng.out_data = 16'($urandom);
    @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle res", {res_valid, done, err}, 0);
    chk("idle fv/iv", {eng.filter_valid, eng.image_valid}, 0);
    pov = 1'b0; pod = '0;
    @(posedge clk); #1;

    for (int c = 1; c <= endc; c++) begin
      busy_e = (c < endc);
      start  = busy_e && ($urandom_range(0, 3) == 0);
      cfg_filter_size = 1'($urandom); cfg_image_size = 4'($urandom);
      cfg_pad_mode = 1'($urandom); cfg_act_mode = 1'($urandom);
      wr_en = busy_e && 1'($urandom); wr_sel = 1'($urandom);
      wr_addr = 6'($urandom); wr_data = 8'($urandom);
      ov = (c >= r0) && (c < r0 + nres);
      eng.out_valid = ov; eng.out_data = 16'($urandom);
      if (c == abort_c) rst = 1'b1;
      @(negedge clk);
      fv_e = busy_e && (c <= k);
      iv_e = busy_e && (c >= img_lo) && (c <= img_hi);
      ein  = fv_e ? fm[c-1] : iv_e ? im[c-img_lo] : 8'sd0;
      chk($sformatf("busy c%0d", c), busy, busy_e);
      chk($sformatf("fv c%0d", c), eng.filter_valid, fv_e);
      chk($sformatf("iv c%0d", c), eng.image_valid, iv_e);
      chk($sformatf("in_data c%0d", c), eng.in_data, ein);
      chk($sformatf("modes c%0d", c),
          {eng.filter_size, eng.image_size, eng.pad_mode, eng.act_mode},
          busy_e ? {fs, 4'(n), pad, act} : 7'd0);
      chk($sformatf("res_valid c%0d", c), res_valid, pov);
      if (pov) chk($sformatf("res_data c%0d", c), res_data, pod);
      chk($sformatf("res_last c%0d", c), res_last, (c == endc) && (mode == 0));
      chk($sformatf("done c%0d", c), done, (c == endc) && (mode == 0));
      chk($sformatf("err c%0d", c), err, (c == endc) && (mode != 0));
      pov = ov; pod = eng.out_data;
      if (c == abort_c) begin
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0; start = 1'b0; eng.out_valid = 1'b0;
        @(negedge clk);
        chk_all_zero("after rst");
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; wr_en = 1'b0; eng.out_valid = 1'b0;
  endtask

  task automatic bad_job(input logic [3:0] n);
    cfg_image_size = n; cfg_filter_size = 1'($urandom);
    start = 1'b1; eng.out_valid = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("bad n=%0d err c%0d", n, c), err, c == 1);
      chk($sformatf("bad n=%0d busy c%0d", n, c), busy, 0);
      chk($sformatf("bad n=%0d fv c%0d", n, c), {eng.filter_valid, eng.image_valid}, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got hang want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] bad_n [5];
    int n, md;
    bit fs;
    bad_n = '{4'd0, 4'd2, 4'd3, 4'd9, 4'd15};
    rst = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; start = 0;
    cfg_filter_size = 0; cfg_image_size = 0; cfg_pad_mode = 0; cfg_act_mode = 0;
    eng.out_valid = 0; eng.out_data = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 25; i++) wr(0, i, 8'(i + 1));
    for (int i = 0; i < 64; i++) wr(1, i, 8'(i + 1));
    run_job(0, 4, 0, 0, 0, 0, 3, 0);

    for (int i = 0; i < 25; i++) wr(0, i, 8'($urandom));
    for (int i = 25; i < 64; i++) wr(0, i, 8'($urandom));
    for (int i = 0; i < 64; i++) wr(1, i, 8'($urandom));
    run_job(1, 8, 1, 1, 0, 0, 5, 0);

    foreach (bad_n[i]) bad_job(bad_n[i]);

    run_job(0, 4, 0, 1, 1, 10, 2, 0);
    run_job(0, 4, 1, 0, 0, 0, 1, 0);
    run_job(0, 4, 0, 0, 2, 0, 0, 0);
    run_job(0, 5, 1, 1, 0, 0, 4, 9 + GAP_N + 5);
    run_job(0, 5, 1, 1, 0, 0, 4, 0);

    for (int j = 0; j < 8; j++) begin
      fs = 1'($urandom);
      n  = int'($urandom_range(4, 8));
      md = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int w = 0; w < 6; w++) wr(1'($urandom), int'($urandom_range(0, 63)), 8'($urandom));
      run_job(fs, n, 1'($urandom), 1'($urandom), md,
              int'($urandom_range(1, n * n - 1)), int'($urandom_range(0, 15)) - 3, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
